// File: rtl/nd_array_tile_packer.sv
// Serial element stream to ROWS x COLS nd-array tile packer with valid/ready on both sides.
// Optional macro NDARRAY_PACKER_DOUBLE_BUFFER_EN adds a second tile bank for gap-free throughput.
module nd_array_tile_packer #(
  parameter int WIDTH = 3,
  parameter int ROWS  = 6,
  parameter int COLS  = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_first,
  output logic             in_ready,
  output logic [WIDTH-1:0] O [ROWS-1:0][COLS-1:0],
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_in_ready;
  logic          r_out_valid;

  logic [RW-1:0] w_row_eff;
  logic [CW-1:0] w_col_eff;
  logic [RW-1:0] w_row_next;
  logic [CW-1:0] w_col_next;
  logic          w_col_wrap;
  logic          w_last;
  logic          w_xfer;
  logic          w_consume;

  // in_first forces the current element to cell [0][0], discarding any partial tile
  assign w_row_eff  = in_first ? '0 : r_row;
  assign w_col_eff  = in_first ? '0 : r_col;
  assign w_col_wrap = (w_col_eff == COL_LAST);
  assign w_last     = w_col_wrap && (w_row_eff == ROW_LAST);
  assign w_col_next = w_col_wrap ? '0 : CW'(w_col_eff + 1'b1);
  assign w_row_next = !w_col_wrap ? w_row_eff :
                      ((w_row_eff == ROW_LAST) ? '0 : RW'(w_row_eff + 1'b1));

  assign w_xfer    = in_valid && r_in_ready;
  assign w_consume = r_out_valid && out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

`ifdef NDARRAY_PACKER_DOUBLE_BUFFER_EN

  logic [WIDTH-1:0] r_bank [2][ROWS-1:0][COLS-1:0];
  logic             r_hold_sel;
  logic             r_fill_done;
  logic             w_fill_sel;

  assign w_fill_sel = ~r_hold_sel;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_row       <= '0;
      r_col       <= '0;
      r_hold_sel  <= 1'b0;
      r_fill_done <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            r_bank[b][r][c] <= '0;
    end else begin
      if (w_xfer) begin
        r_bank[w_fill_sel][w_row_eff][w_col_eff] <= in_data;
        r_row <= w_row_next;
        r_col <= w_col_next;
      end
      // A parked complete tile moves to hold in the same cycle the hold tile leaves
      if (r_fill_done && w_consume) begin
        r_hold_sel  <= ~r_hold_sel;
        r_fill_done <= 1'b0;
        r_in_ready  <= 1'b1;
      end else if (w_xfer && w_last && (!r_out_valid || w_consume)) begin
        r_hold_sel  <= ~r_hold_sel;
        r_out_valid <= 1'b1;
      end else if (w_xfer && w_last) begin
        r_fill_done <= 1'b1;
        r_in_ready  <= 1'b0;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      assign O[gr][gc] = r_bank[r_hold_sel][gr][gc];
    end
  end

`else

  typedef enum logic {S_FILL, S_HOLD} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_tile [ROWS-1:0][COLS-1:0];

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_state     <= S_FILL;
      r_row       <= '0;
      r_col       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_tile[r][c] <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_xfer) begin
            r_tile[w_row_eff][w_col_eff] <= in_data;
            r_row <= w_row_next;
            r_col <= w_col_next;
            if (w_last) begin
              r_state     <= S_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // counters already wrapped to 0 on the last element
          if (w_consume) begin
            r_state     <= S_FILL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      assign O[gr][gc] = r_tile[gr][gc];
    end
  end

`endif

endmodule

// File: tb/tb_nd_array_tile_packer.sv
// Self-checking bench for nd_array_tile_packer: queue-of-tiles reference model plus literal checks.
module tb_nd_array_tile_packer;
  localparam int W = 3;
  localparam int R = 6;
  localparam int C = 4;
  localparam int N = R * C;
`ifdef NDARRAY_PACKER_DOUBLE_BUFFER_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam bit HOLD_IR = (CAP == 2);

  typedef logic [N*W-1:0] tile_t;

  logic         CLK = 1'b0;
  logic         ASYNCRESET = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_first = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] O [R-1:0][C-1:0];

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  nd_array_tile_packer #(.WIDTH(W), .ROWS(R), .COLS(C)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .in_data(in_data), .in_valid(in_valid), .in_first(in_first), .in_ready(in_ready),
    .O(O), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic tile_t o_flat();
    tile_t t;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        t[(r*C+c)*W +: W] = O[r][c];
    return t;
  endfunction

  // Reference model: complete tiles wait in a queue of depth CAP; O is the oldest one
  tile_t m_q[$];
  tile_t m_bank[2];
  int    m_k, m_f, m_idx;
  bit    m_ir, m_ov, m_cons, m_xf;

  always @(negedge CLK) begin
    if (ASYNCRESET) begin
      m_q.delete();
      m_bank[0] = '0;
      m_bank[1] = '0;
      m_k = 0;
      m_f = 0;
    end else begin
      m_ir = (m_q.size() < CAP);
      m_ov = (m_q.size() > 0);
      chk("in_ready", in_ready, m_ir);
      chk("out_valid", out_valid, m_ov);
      if (m_ov) chk("tile", o_flat(), m_q[0]);
      m_cons = m_ov && out_ready;
      m_xf   = m_ir && in_valid;
      if (m_cons) void'(m_q.pop_front());
      if (m_xf) begin
        m_idx = in_first ? 0 : m_k;
        m_bank[m_f][m_idx*W +: W] = in_data;
        m_k = m_idx + 1;
        if (m_k == N) begin
          m_k = 0;
          m_q.push_back(m_bank[m_f]);
          m_f = (m_f + 1) % CAP;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic f, input bit rnd);
    in_data = d;
    in_first = f;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (in_ready) begin
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        $display("xfer data=%0d first=%0d", d, f);
        return;
      end
      @(posedge CLK);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    checks++;
    failures++;
    $display("FAIL send_timeout actual=in_ready_low required=in_ready_high t=%0t", $time);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  tile_t snap;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    ASYNCRESET = 1'b0;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_O", o_flat(), '0);

    // Continuous k mod 8 stream with out_ready high
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) send(W'(k % 8), 1'b0, 1'b0);
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_O00", O[0][0], 3'd0);
    chk("t1_O21", O[2][1], 3'd1);
    chk("t1_O53", O[5][3], 3'd7);
    cycle();
    chk("t1_in_ready_next", in_ready, 1'b1);

    // Hold with out_ready low for 10 cycles
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) send(W'((k * 5 + 1) % 8), 1'b0, 1'b0);
    snap = o_flat();
    chk("t2_O00", O[0][0], 3'd1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t2_hold_in_ready", in_ready, HOLD_IR);
      chk("t2_hold_O", o_flat(), snap);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("t2_after_out_valid", out_valid, 1'b0);
    chk("t2_after_in_ready", in_ready, 1'b1);

    // Resync: 7 x 2, first with 5, 23 x 6
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) send(3'd2, 1'b0, 1'b0);
    send(3'd5, 1'b1, 1'b0);
    for (int k = 0; k < 23; k++) send(3'd6, 1'b0, 1'b0);
    chk("t3_out_valid", out_valid, 1'b1);
    chk("t3_O00", O[0][0], 3'd5);
    chk("t3_O01", O[0][1], 3'd6);
    chk("t3_O32", O[3][2], 3'd6);
    chk("t3_O53", O[5][3], 3'd6);
    cycle();

    // Asynchronous reset mid-fill
    for (int k = 0; k < 12; k++) send(3'd3, 1'b0, 1'b0);
    #2;
    ASYNCRESET = 1'b1;
    #1;
    chk("t4_rst_out_valid", out_valid, 1'b0);
    chk("t4_rst_in_ready", in_ready, 1'b1);
    chk("t4_rst_O", o_flat(), '0);
    @(negedge CLK);
    cycle();
    ASYNCRESET = 1'b0;
    for (int k = 0; k < N; k++) send(W'((k * 3) % 8), 1'b0, 1'b0);
    chk("t4_out_valid", out_valid, 1'b1);
    chk("t4_O00", O[0][0], 3'd0);
    chk("t4_O01", O[0][1], 3'd3);
    chk("t4_O53", O[5][3], 3'd5);
    cycle();

    // 50% duty gaps on in_valid
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 1) == 1) cycle();
      send(W'(k % 8), 1'b0, 1'b0);
    end
    chk("t5_out_valid", out_valid, 1'b1);
    chk("t5_O00", O[0][0], 3'd0);
    chk("t5_O21", O[2][1], 3'd1);
    chk("t5_O53", O[5][3], 3'd7);
    cycle();

`ifdef NDARRAY_PACKER_DOUBLE_BUFFER_EN
    // Two tiles back to back with no consumer
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) send(W'(k % 8), 1'b0, 1'b0);
    for (int k = 0; k < N; k++) send(W'((k + 3) % 8), 1'b0, 1'b0);
    @(negedge CLK);
    chk("t6_in_ready", in_ready, 1'b0);
    chk("t6_out_valid", out_valid, 1'b1);
    chk("t6_tile1_O00", O[0][0], 3'd0);
    chk("t6_tile1_O10", O[1][0], 3'd4);
    cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("t6_tile2_O00", O[0][0], 3'd3);
    chk("t6_tile2_O10", O[1][0], 3'd7);
    chk("t6_in_ready_after", in_ready, 1'b1);
    out_ready = 1'b1;
    cycle();
    cycle();
`endif

    // Random data, gaps, occasional resync and random back-pressure
    for (int k = 0; k < 3 * N; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        out_ready = 1'($urandom_range(0, 1));
        cycle();
      end
      send(W'($urandom_range(0, 7)), 1'($urandom_range(0, 15) == 0), 1'b1);
    end
    out_ready = 1'b1;
    repeat (10) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
